// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider.
package div_pkg;

    // Default operand width: dividend and quotient are 2N bits, divisor and remainder N bits.
    localparam int unsigned DefaultN = 8;

    // Divide-by-zero returns a quotient of all ones; replicated to 2N bits at use.
    localparam logic DzQuotientBit = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit, trial-subtract.
module sdiv_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0] rem_i,
    input  logic       bit_i,
    input  logic [N:0] dsr_abs_i,
    output logic [N:0] rem_o,
    output logic       qbit_o
);

    logic [N+1:0] diff;

    // Keep the difference when non-negative, otherwise restore the shifted remainder.
    always_comb begin
        diff   = {rem_i, bit_i} - {1'b0, dsr_abs_i};
        qbit_o = ~diff[N+1];
        rem_o  = qbit_o ? diff[N:0] : {rem_i[N-1:0], bit_i};
    end

endmodule

// File: rtl/seq_sdiv_2nxn.sv
// Iterative 2N/N signed divider, one quotient bit per clock, valid/ready on both sides.
module seq_sdiv_2nxn
    import div_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           ovf
);

    localparam int unsigned CntW = $clog2(2 * N);

    div_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // Dividend magnitude; quotient bits shift in from the bottom as dividend bits leave the top.
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N:0]     dsr_q, dsr_d;
    logic [N:0]     rem_q, rem_d;
    logic           q_neg_q, q_neg_d;
    logic           r_neg_q, r_neg_d;
    logic           dz_cap_q, dz_cap_d;
    logic           ovf_cap_q, ovf_cap_d;
    logic [2*N-1:0] quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           div_zero_q, div_zero_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;

    logic [2*N-1:0] dvd_abs;
    logic [N:0]     dsr_sx;
    logic [N:0]     dsr_abs;
    logic [N:0]     step_rem;
    logic           step_qbit;

    // Operand magnitudes. As an unsigned 2N-bit value, |-2^(2N-1)| = 2^(2N-1) is exact.
    always_comb begin
        dvd_abs = dividend[2*N-1] ? (~dividend + (2*N)'(1)) : dividend;
        dsr_sx  = {divisor[N-1], divisor};
        dsr_abs = divisor[N-1] ? (~dsr_sx + (N+1)'(1)) : dsr_sx;
    end

    sdiv_step #(
        .N (N)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[2*N-1]),
        .dsr_abs_i (dsr_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Next-state logic: FSM, iteration counter, operand capture and sign fix-up.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_cap_d    = dz_cap_q;
        ovf_cap_d   = ovf_cap_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvd_d      = dvd_abs;
                    dsr_d      = dsr_abs;
                    rem_d      = '0;
                    q_neg_d    = dividend[2*N-1] ^ divisor[N-1];
                    r_neg_d    = dividend[2*N-1];
                    dz_cap_d   = (divisor == '0);
                    ovf_cap_d  = (dividend == {1'b1, {(2*N-1){1'b0}}}) && (divisor == '1);
                    cnt_d      = CntW'(2 * N - 1);
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = (divisor == '0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[2*N-2:0], step_qbit};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (dz_cap_q) begin
                    quotient_d  = {(2*N){DzQuotientBit}};
                    remainder_d = '0;
                end else begin
                    // Overflow case needs no special path: 2^(2N-1) wraps to itself.
                    quotient_d  = q_neg_q ? (~dvd_q + (2*N)'(1)) : dvd_q;
                    remainder_d = r_neg_q ? (~rem_q[N-1:0] + N'(1)) : rem_q[N-1:0];
                end
                div_zero_d  = dz_cap_q;
                ovf_d       = ovf_cap_q;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_cap_q    <= 1'b0;
            ovf_cap_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_cap_q    <= dz_cap_d;
            ovf_cap_q   <= ovf_cap_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Output mapping.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = out_valid_q;
        quotient  = quotient_q;
        remainder = remainder_q;
        div_zero  = div_zero_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_seq_sdiv_2nxn.sv
// Self-checking bench for seq_sdiv_2nxn: directed corner cases, backpressure,
// mid-operation reset and random operands against a $signed reference.
module tb_seq_sdiv_2nxn;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    seq_sdiv_2nxn #(
        .N (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: Verilog signed / and %, plus the divide-by-zero and overflow rules.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   sa;
        int   sb;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = 18;
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = 8'd0;
            e.dz  = 1'b1;
            e.lat = 2;
        end else if (a == 16'h8000 && b == 8'hFF) begin
            e.q   = 16'h8000;
            e.r   = 8'd0;
            e.ovf = 1'b1;
        end else begin
            e.q = 16'(sa / sb);
            e.r = 8'(sa % sb);
        end
        return e;
    endfunction

    // Called at posedge+1. Latency counts the accept edge as clock 1.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        exp_t        e;
        int          n;
        int          lat;
        logic [15:0] q0;
        logic [7:0]  r0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb_q.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        q0 = quotient;
        r0 = remainder;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = ~a;
            divisor  = 8'd1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_q_stable", 32'(quotient), 32'(q0));
            check("bp_r_stable", 32'(remainder), 32'(r0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("ovf", 32'(ovf), 32'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("consumed", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          seen_valid;
        logic [15:0] ra;
        logic [7:0]  rb;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_flags", 32'({div_zero, ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(16'd100, 8'd7, 0);
        run_op(16'hFF9C, 8'd7, 0);
        run_op(16'd100, 8'hF9, 0);
        run_op(16'h8000, 8'hFF, 0);
        run_op(16'h8000, 8'h80, 0);
        run_op(16'd5, 8'd0, 0);
        run_op(16'h7FFF, 8'h80, 0);
        run_op(16'd1234, 8'd10, 5);

        // Abort an operation in its ninth CALC cycle.
        dividend = 16'd1000;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1;
        end
        check("midrst_no_result", 32'(seen_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op(16'hFC18, 8'hFD, 0);

        for (int k = 0; k < 1500; k++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 15))
                0: ra = 16'h8000;
                1: rb = 8'hFF;
                2: rb = 8'h80;
                3: rb = 8'd0;
                default: ;
            endcase
            run_op(ra, rb, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
